// File: rtl/cal_pkg.sv
// Shared calendar helpers: BCD day-pair type, month-index constants and
// month-length / BCD step functions used by the day-of-month counter.
package cal_pkg;

  localparam int TENS_W  = 2;
  localparam int UNITS_W = 4;
  localparam int DAY_W   = TENS_W + UNITS_W;

  // Zero-based month indices of the months shorter than 31 days
  localparam int FEB = 1;
  localparam int APR = 3;
  localparam int JUN = 5;
  localparam int SEP = 8;
  localparam int NOV = 10;

  typedef struct packed {
    logic [TENS_W-1:0]  tens;
    logic [UNITS_W-1:0] units;
  } bcd_day_t;

  // Returns the last valid day of the month in the day_base encoding.
  // Out-of-range month indices fall back to a 31-day month.
  function automatic bcd_day_t month_last_day(
    input logic               m_tens,
    input logic [UNITS_W-1:0] m_units,
    input logic               leap,
    input int                 day_base,
    input int                 month_base
  );
    int m;
    int len;
    int last;
    bcd_day_t r;
    m = (m_tens ? 10 : 0) + int'(m_units) - month_base;
    case (m)
      FEB:                len = leap ? 29 : 28;
      APR, JUN, SEP, NOV: len = 30;
      default:            len = 31;
    endcase
    last    = day_base + len - 1;
    r.tens  = TENS_W'(last / 10);
    r.units = UNITS_W'(last % 10);
    return r;
  endfunction

  function automatic bcd_day_t bcd_inc(input bcd_day_t d);
    bcd_day_t r;
    r = d;
    if (d.units >= 4'd9) begin
      r.units = '0;
      r.tens  = d.tens + 2'd1;
    end else begin
      r.units = d.units + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_day_t bcd_dec(input bcd_day_t d);
    bcd_day_t r;
    r = d;
    if (d.units == 4'd0) begin
      r.units = 4'd9;
      r.tens  = d.tens - 2'd1;
    end else begin
      r.units = d.units - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_step_gen.sv
// Turns a synchronised button level into step pulses: one on the press,
// then one every REPEAT_CYC cycles while the button stays held.
module btn_step_gen #(
  parameter int REPEAT_CYC = 50000000,
  parameter int RPT_W      = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn,
  output logic step
);

  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYC - 1);

  logic             btnPrev;
  logic             armed;
  logic             active;
  logic [RPT_W-1:0] rptCnt;
  logic             rise;
  logic             repeatHit;

  // armed stays low after reset until the button has been seen released,
  // so a button held through reset does not fire a fresh press.
  assign rise      = en & btn & ~btnPrev & armed;
  assign repeatHit = en & btn & active & (rptCnt == RPT_LAST);
  assign step      = rise | repeatHit;

  always_ff @(posedge clk) begin
    if (rst) begin
      btnPrev <= 1'b0;
      armed   <= 1'b0;
      active  <= 1'b0;
      rptCnt  <= '0;
    end else begin
      btnPrev <= btn;
      if (!btn) armed <= 1'b1;
      if (!en || !btn) begin
        active <= 1'b0;
        rptCnt <= '0;
      end else if (rise) begin
        active <= 1'b1;
        rptCnt <= '0;
      end else if (active) begin
        rptCnt <= repeatHit ? '0 : rptCnt + RPT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_day_of_month_counter.sv
// BCD day-of-month register pair: advances on day_tick, wraps at the month
// length (leap aware), clamps on month changes and supports manual stepping.
module bcd_day_of_month_counter
  import cal_pkg::*;
#(
  parameter int DAY_BASE   = 1,
  parameter int MONTH_BASE = 1,
  parameter int REPEAT_CYC = 50000000,
  parameter int RPT_W      = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         day_tick,
  input  logic         set_mode,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         month_tens,
  input  logic [3:0]   month_units,
  input  logic         leap,
  output logic [1:0]   day_tens,
  output logic [3:0]   day_units,
  output logic         month_carry
);

  bcd_day_t dayQ;
  bcd_day_t dayNext;
  bcd_day_t lastDay;
  bcd_day_t firstDay;
  logic     carryQ;
  logic     carryNext;
  logic     stepUp;
  logic     stepDown;
  logic     needClamp;
  logic     atLast;
  logic     atFirst;

  btn_step_gen #(
    .REPEAT_CYC (REPEAT_CYC),
    .RPT_W      (RPT_W)
  ) u_step_up (
    .clk  (clk),
    .rst  (rst),
    .en   (set_mode),
    .btn  (btn_up),
    .step (stepUp)
  );

  btn_step_gen #(
    .REPEAT_CYC (REPEAT_CYC),
    .RPT_W      (RPT_W)
  ) u_step_down (
    .clk  (clk),
    .rst  (rst),
    .en   (set_mode),
    .btn  (btn_down),
    .step (stepDown)
  );

  assign firstDay = '{tens: 2'd0, units: 4'(DAY_BASE)};
  assign lastDay  = month_last_day(month_tens, month_units, leap, DAY_BASE, MONTH_BASE);

  // With valid BCD units the packed pair orders the same as the day number.
  assign needClamp = (dayQ.units > 4'd9) || (dayQ > lastDay);
  assign atLast    = (dayQ == lastDay);
  assign atFirst   = (dayQ == firstDay);

  always_comb begin
    dayNext   = dayQ;
    carryNext = 1'b0;
    if (needClamp) begin
      dayNext = lastDay;
    end else if (!set_mode) begin
      if (day_tick) begin
        if (atLast) begin
          dayNext   = firstDay;
          carryNext = 1'b1;
        end else begin
          dayNext = bcd_inc(dayQ);
        end
      end
    end else if (stepUp && !stepDown) begin
      dayNext = atLast ? firstDay : bcd_inc(dayQ);
    end else if (stepDown && !stepUp) begin
      dayNext = atFirst ? lastDay : bcd_dec(dayQ);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dayQ   <= firstDay;
      carryQ <= 1'b0;
    end else begin
      dayQ   <= dayNext;
      carryQ <= carryNext;
    end
  end

  assign day_tens    = dayQ.tens;
  assign day_units   = dayQ.units;
  assign month_carry = carryQ;

endmodule
